// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display controller: segment bit
// positions and the hex-to-segment table (active-high, bit 6 = g ... bit 0 = a).
package seg7_pkg;

  localparam int unsigned SEG_DP = 7;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_A  = 0;

  localparam logic [6:0] SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] seg7_hex(input logic [3:0] nibble);
    return SEG_HEX[nibble];
  endfunction

endpackage

// File: rtl/seg7_hex_encode.sv
// Combinational hex nibble to g..a segment pattern (active-high).
module seg7_hex_encode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_c
);

  logic [6:0] code;

  // Table column order is g..a; place each bit at its named position
  always_comb begin
    code         = seg7_hex(nibble);
    seg_c        = '0;
    seg_c[SEG_A] = code[0];
    seg_c[SEG_B] = code[1];
    seg_c[SEG_C] = code[2];
    seg_c[SEG_D] = code[3];
    seg_c[SEG_E] = code[4];
    seg_c[SEG_F] = code[5];
    seg_c[SEG_G] = code[6];
  end

endmodule

// File: rtl/seg7_mux_ctrl.sv
// Multiplexed seven-segment controller: shadowed data, PWM brightness,
// decimal points, leading-zero blanking and per-digit blinking.
module seg7_mux_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 8,
  parameter int unsigned SCAN_DIV    = 4096,
  parameter int unsigned BLINK_SCANS = 64,
  parameter int unsigned ACTIVE_LOW  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   data,
  input  logic [NUM_DIGITS-1:0]     dp,
  input  logic [NUM_DIGITS-1:0]     blink_mask,
  input  logic                      blank_lz,
  input  logic [3:0]                brightness,
  output logic [NUM_DIGITS-1:0]     an,
  output logic [7:0]                seg_code
);

  localparam int unsigned SUB_LEN = SCAN_DIV / 16;
  localparam int unsigned DIV_W   = $clog2(SCAN_DIV);
  localparam int unsigned PRE_W   = (SUB_LEN > 1) ? $clog2(SUB_LEN) : 1;
  localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);
  localparam int unsigned BLINK_W = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
  localparam logic        POL     = (ACTIVE_LOW != 0);

  logic [NUM_DIGITS-1:0][3:0] data_sh;
  logic [NUM_DIGITS-1:0]      dp_sh;
  logic [NUM_DIGITS-1:0]      blink_sh;
  logic [NUM_DIGITS-1:0]      lz_mask;
  logic [NUM_DIGITS-1:0]      lz_next;
  logic                       lz_run;

  logic [DIV_W-1:0]   div;
  logic [PRE_W-1:0]   pre;
  logic [3:0]         sub;
  logic [IDX_W-1:0]   idx;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;

  logic                  div_wrap;
  logic                  pre_wrap;
  logic                  last_digit;
  logic                  lit;
  logic                  blanked;
  logic [3:0]            cur_nibble;
  logic [6:0]            hex_seg;
  logic [NUM_DIGITS-1:0] an_nxt;
  logic [7:0]            seg_nxt;

  assign div_wrap   = (div == DIV_W'(SCAN_DIV - 1));
  assign pre_wrap   = (pre == PRE_W'(SUB_LEN - 1));
  assign last_digit = (idx == IDX_W'(NUM_DIGITS - 1));
  assign cur_nibble = data_sh[idx];

  seg7_hex_encode u_hex (
    .nibble (cur_nibble),
    .seg_c  (hex_seg)
  );

  // A digit is a leading zero when it and every more significant nibble are 0
  always_comb begin
    lz_run  = 1'b1;
    lz_next = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lz_run = lz_run & (data_sh[i] == 4'h0);
      if (i != 0) lz_next[i] = lz_run;
    end
  end

  // Active-high next output; segments are forced off whenever the anode is off
  always_comb begin
    lit     = (sub < brightness) && !(blink_phase && blink_sh[idx]);
    blanked = blank_lz && lz_mask[idx];
    an_nxt  = '0;
    seg_nxt = '0;
    if (lit) begin
      an_nxt[idx]            = 1'b1;
      seg_nxt[SEG_G:SEG_A]   = blanked ? 7'h00 : hex_seg;
      seg_nxt[SEG_DP]        = dp_sh[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_sh     <= '0;
      dp_sh       <= '0;
      blink_sh    <= '0;
      lz_mask     <= '0;
      div         <= '0;
      pre         <= '0;
      sub         <= '0;
      idx         <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      an          <= {NUM_DIGITS{POL}};
      seg_code    <= {8{POL}};
    end else begin
      if (load) begin
        data_sh  <= data;
        dp_sh    <= dp;
        blink_sh <= blink_mask;
      end
      lz_mask <= lz_next;

      div <= div_wrap ? '0 : div + DIV_W'(1);
      pre <= (pre_wrap || div_wrap) ? '0 : pre + PRE_W'(1);
      if (div_wrap)      sub <= '0;
      else if (pre_wrap) sub <= sub + 4'd1;

      if (div_wrap) idx <= last_digit ? '0 : idx + IDX_W'(1);

      // Blink phase flips after BLINK_SCANS complete frames
      if (div_wrap && last_digit) begin
        if (blink_cnt == BLINK_W'(BLINK_SCANS - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BLINK_W'(1);
        end
      end

      an       <= an_nxt ^ {NUM_DIGITS{POL}};
      seg_code <= seg_nxt ^ {8{POL}};
    end
  end

endmodule

// File: tb/tb_seg7_mux_ctrl.sv
// Directed self-checking bench for seg7_mux_ctrl (4 digits, 32-cycle slots,
// 2-frame blink, active-low outputs).
module tb_seg7_mux_ctrl;

  localparam int unsigned ND    = 4;
  localparam int unsigned SD    = 32;
  localparam int unsigned BS    = 2;
  localparam int          FRAME = ND * SD;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] data;
  logic [3:0]  dp;
  logic [3:0]  blink_mask;
  logic        blank_lz;
  logic [3:0]  brightness;
  logic [3:0]  an;
  logic [7:0]  seg_code;

  int         checks = 0;
  int         errors = 0;
  int         cnt [ND];
  logic [7:0] segv [ND];
  int         multi;
  int         darkseg;

  always #5 clk = ~clk;

  seg7_mux_ctrl #(
    .NUM_DIGITS  (ND),
    .SCAN_DIV    (SD),
    .BLINK_SCANS (BS),
    .ACTIVE_LOW  (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .data       (data),
    .dp         (dp),
    .blink_mask (blink_mask),
    .blank_lz   (blank_lz),
    .brightness (brightness),
    .an         (an),
    .seg_code   (seg_code)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reset, load the shadow on the release cycle, then skip frame 0
  task automatic restart(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; load = 1'b1; data = d; dp = p; blink_mask = b;
    @(posedge clk);
    #1;
    load = 1'b0;
    repeat (FRAME - 1) @(posedge clk);
    #1;
  endtask

  // Observe one full frame; optionally pulse load after sample load_at
  task automatic capture(input int load_at, input logic [15:0] ld);
    int act;
    for (int d = 0; d < ND; d++) begin
      cnt[d]  = 0;
      segv[d] = 8'hFF;
    end
    multi   = 0;
    darkseg = 0;
    for (int j = 0; j < FRAME; j++) begin
      @(posedge clk);
      #1;
      load = 1'b0;
      act  = 0;
      for (int d = 0; d < ND; d++) begin
        if (an[d] == 1'b0) begin
          act++;
          cnt[d]++;
          segv[d] = seg_code;
        end
      end
      if (act > 1) multi++;
      if (act == 0 && seg_code !== 8'hFF) darkseg++;
      if (j == load_at) begin
        load = 1'b1;
        data = ld;
      end
    end
    check("onehot", 8'(multi), 8'd0);
    check("dark_seg", 8'(darkseg), 8'd0);
  endtask

  // Expected counts/segments packed with digit 3 in the top byte
  task automatic check_frame(input string tag, input logic [31:0] cnts, input logic [31:0] segs);
    for (int d = 0; d < ND; d++) begin
      check($sformatf("%s_d%0d_cnt", tag, d), 8'(cnt[d]), cnts[d*8 +: 8]);
      check($sformatf("%s_d%0d_seg", tag, d), segv[d], segs[d*8 +: 8]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; load = 1'b0; data = '0; dp = '0; blink_mask = '0;
    blank_lz = 1'b0; brightness = 4'd15;
    repeat (3) @(posedge clk);
    #1;
    check("rst_an", 8'(an), 8'h0F);
    check("rst_seg", seg_code, 8'hFF);

    rst = 1'b0; load = 1'b1; data = 16'h12AF;
    @(posedge clk);
    #1;
    load = 1'b0;
    check("first_an", 8'(an), 8'h0E);
    check("first_seg", seg_code, 8'hC0);
    repeat (FRAME - 1) @(posedge clk);
    #1;

    capture(-1, 16'h0);
    check_frame("basic", {8'd30, 8'd30, 8'd30, 8'd30}, {8'hF9, 8'hA4, 8'h88, 8'h8E});

    brightness = 4'd4;
    capture(-1, 16'h0);
    check_frame("pwm4", {8'd8, 8'd8, 8'd8, 8'd8}, {8'hF9, 8'hA4, 8'h88, 8'h8E});

    brightness = 4'd0;
    capture(-1, 16'h0);
    check_frame("pwm0", {8'd0, 8'd0, 8'd0, 8'd0}, {8'hFF, 8'hFF, 8'hFF, 8'hFF});

    brightness = 4'd15; blank_lz = 1'b1;
    restart(16'h0030, 4'b0100, 4'b0000);
    capture(-1, 16'h0);
    check_frame("lz_on", {8'd30, 8'd30, 8'd30, 8'd30}, {8'hFF, 8'h7F, 8'hB0, 8'hC0});
    blank_lz = 1'b0;
    capture(-1, 16'h0);
    check_frame("lz_off", {8'd30, 8'd30, 8'd30, 8'd30}, {8'hC0, 8'h40, 8'hB0, 8'hC0});

    restart(16'h0008, 4'b0001, 4'b0001);
    capture(-1, 16'h0);
    check_frame("blink_f1", {8'd30, 8'd30, 8'd30, 8'd30}, {8'hC0, 8'hC0, 8'hC0, 8'h00});
    capture(-1, 16'h0);
    check_frame("blink_f2", {8'd30, 8'd30, 8'd30, 8'd0}, {8'hC0, 8'hC0, 8'hC0, 8'hFF});
    capture(-1, 16'h0);
    check_frame("blink_f3", {8'd30, 8'd30, 8'd30, 8'd0}, {8'hC0, 8'hC0, 8'hC0, 8'hFF});
    capture(-1, 16'h0);
    check_frame("blink_f4", {8'd30, 8'd30, 8'd30, 8'd30}, {8'hC0, 8'hC0, 8'hC0, 8'h00});
    capture(-1, 16'h0);
    check_frame("blink_f5", {8'd30, 8'd30, 8'd30, 8'd30}, {8'hC0, 8'hC0, 8'hC0, 8'h00});

    brightness = 4'd4;
    restart(16'h1234, 4'b0000, 4'b0000);
    capture(74, 16'h5678);
    check_frame("midload_a", {8'd8, 8'd8, 8'd8, 8'd8}, {8'h92, 8'hA4, 8'hB0, 8'h99});
    capture(-1, 16'h0);
    check_frame("midload_b", {8'd8, 8'd8, 8'd8, 8'd8}, {8'h92, 8'h82, 8'hF8, 8'h80});

    brightness = 4'd15;
    restart(16'h1234, 4'b0000, 4'b0000);
    repeat (40) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_an", 8'(an), 8'h0F);
    check("midrst_seg", seg_code, 8'hFF);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("restart_an", 8'(an), 8'h0E);
    check("restart_seg", seg_code, 8'hC0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
